key_note_select: RTL and testbench
==================================

// Module: key_note_select
// PURPOSE
// Upstream stage of the piano tone generator. Scans NUM_KEYS active-high key inputs,
// synchronises and debounces each one, and applies last-note-priority monophonic selection.
// Publishes the selected note as a half-period divider word plus a valid flag.
// The downstream square-wave tone generator consumes that word directly.
// PARAMETERS
// CLK_HZ        25000000  system clock frequency, Hz
// NUM_KEYS      12        key inputs, index 0 = A4 ... 11 = G#5 (semitone steps)
// TICK_CYCLES   25000     debounce sample period in clk cycles (1 ms at 25 MHz)
// STABLE_TICKS  10        consecutive agreeing samples needed to change a debounced state
// DIV_W         16        width of half_period
// PORTS
// clk           in   1         system clock, all logic on rising edge
// rst_n         in   1         asynchronous active-low reset
// keys          in   NUM_KEYS  raw key levels, asynchronous, 1 = pressed
// note_valid    out  1         1 = a note is selected and the speaker must sound
// note_idx      out  4         index of the selected key (0 when !note_valid)
// half_period   out  DIV_W     tone divider: tone gen toggles when its counter == half_period
// note_changed  out  1         one-cycle pulse whenever any of the three outputs above changes
// BEHAVIOUR
// - Reset (rst_n=0, async): all outputs 0; prescaler 0; every debounced key = released;
//   all stable counters 0; synchroniser flops 0.
// - Sync: each keys[i] passes through a 2-flop synchroniser before any other use.
// - Prescaler: counts 0..TICK_CYCLES-1 and wraps; tick = 1 for one cycle at wrap.
// - Debounce, per key, evaluated on tick only:
//   - sync != deb: cnt++.
//   - cnt reaches STABLE_TICKS: deb flips, cnt clears, and a one-cycle rise/fall event fires.
//   - sync == deb: cnt clears.
//   - Pulses shorter than STABLE_TICKS ticks never change deb.
// - Selection, evaluated in the cycle after a tick that produced any event:
//   - Any rise events: select the lowest-index key among the keys that rose.
//   - Else, if the current key fell: select the lowest-index key still debounced-pressed; none -> idle.
//   - Else (only non-current keys fell): no change.
//   - Rise and fall of the current key on the same tick: the rise rule wins.
// - Outputs are registered. They update one clk after the selection cycle, so the latency
//   from the debounce tick to the outputs is 2 clk.
//   - Idle: note_valid=0, note_idx=0, half_period=0.
//   - note_changed pulses only if the new {valid,idx,half_period} differs from the old value.
//   - Reselecting the same note produces no pulse.
// - half_period = floor(CLK_HZ*1000 / (2*f_mHz[idx])) - 1, computed at elaboration with 64-bit math.
//   - f_mHz: 440000 466164 493883 523251 554365 587330 622254 659255 698456 739989 783991 830609.
//   - At 25 MHz: idx0 28408, idx3 23888, idx7 18959, idx11 15048.
//   - Elaboration error if any value exceeds 2^DIV_W-1.
// - Downstream contract: the tone generator restarts its counter on note_changed and mutes while !note_valid.
// - Keys held through reset: they are re-detected as fresh presses after STABLE_TICKS ticks.
// STRUCTURE
// - Package piano_pkg: NOTE_FREQ_MHZ[12] table, NUM_NOTES=12, and function half_period_of(clk_hz, idx).
//   The tone generator shares this package.
// - Sub-module key_debounce: synchroniser, stable counter, debounced level, rise/fall pulses.
//   One instance per key via generate; the shared tick is an input.
// - Top level: prescaler, selection logic, output registers, change detect.
// TESTING (TICK_CYCLES=4, STABLE_TICKS=3, CLK_HZ=25000000)
// 1. Reset, keys=0 -> all outputs 0, no note_changed pulses for 200 cycles.
// 2. keys[0]=1 held -> within 2+3*4+2 cycles: valid=1, idx=0, half_period=28408, one note_changed pulse.
// 3. keys[4] toggles 1 for 6 cycles, then 0 -> outputs unchanged, no note_changed.
// 4. Hold key0, then press key7 -> idx=7, half_period=18959.
//    Release key7 -> idx=0, half_period=28408. Release key0 -> valid=0, half_period=0.
// 5. Keys 3 and 5 rise in the same cycle -> idx=3, half_period=23888.
//    Release key5 -> no change. Release key3 -> idle.
// 6. Key11 sounding, drop rst_n mid-cycle -> outputs 0 immediately, no clock needed.
//    Release rst_n with key11 still held -> idx=11, half_period=15048 after debounce.

Source files
------------

// File: rtl/piano_pkg.sv
// Note table and divider helper shared by the key selector and the tone generator.
// Frequencies are in millihertz so semitone steps stay exact in integer math.
package piano_pkg;

   localparam int NUM_NOTES = 12;

   localparam longint unsigned NOTE_FREQ_MHZ [NUM_NOTES] = '{
      64'd440000, 64'd466164, 64'd493883, 64'd523251, 64'd554365, 64'd587330,
      64'd622254, 64'd659255, 64'd698456, 64'd739989, 64'd783991, 64'd830609
   };

   // Tone generator toggles when its counter equals this value, hence the -1.
   function automatic longint unsigned half_period_of(input longint unsigned clk_hz,
                                                      input int idx);
      return (clk_hz * 64'd1000) / (64'd2 * NOTE_FREQ_MHZ[idx]) - 64'd1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, tick-sampled stable counter, debounced level and
// single-cycle rise/fall events aligned with the debounced level change.
module key_debounce #(
   parameter int STABLE_TICKS = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   input  logic tick_i,
   output logic deb_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = $clog2(STABLE_TICKS + 1);

   logic          meta_q;
   logic          sync_q;
   logic          deb_q;
   logic          rise_q;
   logic          fall_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         deb_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         meta_q <= key_i;
         sync_q <= meta_q;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         if (tick_i) begin
            if (sync_q != deb_q) begin
               // The tick that completes the run flips the level and reports the edge.
               if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                  deb_q  <= sync_q;
                  cnt_q  <= '0;
                  rise_q <= sync_q;
                  fall_q <= !sync_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end else begin
               cnt_q <= '0;
            end
         end
      end
   end

   assign deb_o  = deb_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/key_note_select.sv
// Debounced key scan with last-note-priority monophonic selection; publishes the
// selected note as a half-period divider word for the square-wave tone generator.
module key_note_select
   import piano_pkg::*;
#(
   parameter int CLK_HZ       = 25000000,
   parameter int NUM_KEYS     = 12,
   parameter int TICK_CYCLES  = 25000,
   parameter int STABLE_TICKS = 10,
   parameter int DIV_W        = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] keys,
   output logic                note_valid,
   output logic [3:0]          note_idx,
   output logic [DIV_W-1:0]    half_period,
   output logic                note_changed
);

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   logic [PW-1:0]       pre_q;
   logic                tick;
   logic [NUM_KEYS-1:0] deb;
   logic [NUM_KEYS-1:0] rise;
   logic [NUM_KEYS-1:0] fall;
   logic [DIV_W-1:0]    hp_rom [NUM_KEYS];

   logic             valid_q, valid_d;
   logic [3:0]       idx_q, idx_d;
   logic [DIV_W-1:0] hp_q, hp_d;
   logic             changed_q, changed_d;

   if (NUM_KEYS > NUM_NOTES) begin : g_keys_err
      $error("NUM_KEYS exceeds the note table size");
   end

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      localparam longint unsigned HP = half_period_of(64'(CLK_HZ), g);
      if (HP > ((64'd1 << DIV_W) - 64'd1)) begin : g_hp_err
         $error("half_period of note %0d does not fit in DIV_W bits", g);
      end
      assign hp_rom[g] = DIV_W'(HP);

      key_debounce #(
         .STABLE_TICKS(STABLE_TICKS)
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .key_i (keys[g]),
         .tick_i(tick),
         .deb_o (deb[g]),
         .rise_o(rise[g]),
         .fall_o(fall[g])
      );
   end

   assign tick = (pre_q == PW'(TICK_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else if (tick) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

   function automatic logic [3:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
      lowest_idx = 4'd0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (v[k]) lowest_idx = 4'(k);
      end
   endfunction

   // A fresh press always wins; losing the sounding key falls back to the lowest held one.
   always_comb begin
      valid_d = valid_q;
      idx_d   = idx_q;
      if (|rise) begin
         valid_d = 1'b1;
         idx_d   = lowest_idx(rise);
      end else if (valid_q && fall[idx_q]) begin
         valid_d = |deb;
         idx_d   = lowest_idx(deb);
      end
      hp_d      = valid_d ? hp_rom[idx_d] : '0;
      changed_d = ({valid_d, idx_d, hp_d} != {valid_q, idx_q, hp_q});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         idx_q     <= 4'd0;
         hp_q      <= '0;
         changed_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         hp_q      <= hp_d;
         changed_q <= changed_d;
      end
   end

   assign note_valid   = valid_q;
   assign note_idx     = idx_q;
   assign half_period  = hp_q;
   assign note_changed = changed_q;

endmodule

// File: tb/tb_key_note_select.sv
// Directed bench for key_note_select with a fast debounce (4-cycle tick, 3 stable ticks).
module tb_key_note_select;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] keys = '0;
   logic        note_valid;
   logic [3:0]  note_idx;
   logic [15:0] half_period;
   logic        note_changed;

   int tests = 0;
   int fails = 0;
   int chg_total = 0;

   key_note_select #(
      .CLK_HZ      (25000000),
      .NUM_KEYS    (12),
      .TICK_CYCLES (4),
      .STABLE_TICKS(3),
      .DIV_W       (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .keys        (keys),
      .note_valid  (note_valid),
      .note_idx    (note_idx),
      .half_period (half_period),
      .note_changed(note_changed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (note_changed === 1'b1) chg_total <= chg_total + 1;
   end

   task automatic wait_out(input logic ev, input logic [3:0] ei, input logic [15:0] eh,
                           input int maxc, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         if (note_valid === ev && note_idx === ei && half_period === eh) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int c = 0; c < n; c++) @(negedge clk);
   endtask

   task automatic test_reset;
      int base;
      bit bad;
      #12;
      tests++;
      if ({note_valid, note_idx, half_period, note_changed} !== 22'd0) begin
         fails++;
         $display("FAIL reset_outputs: got v=%0b i=%0d hp=%0d c=%0b, want all 0",
                  note_valid, note_idx, half_period, note_changed);
      end
      @(negedge clk);
      rst_n = 1'b1;
      base = chg_total;
      bad = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if ({note_valid, note_idx, half_period} !== 21'd0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL idle_outputs: outputs left 0 during 200 idle cycles, want 0");
      end
      tests++;
      if (chg_total - base !== 0) begin
         fails++;
         $display("FAIL idle_pulses: got %0d note_changed pulses, want 0", chg_total - base);
      end
   endtask

   task automatic test_single_press;
      int base;
      bit ok;
      base = chg_total;
      keys[0] = 1'b1;
      wait_out(1'b1, 4'd0, 16'd28408, 20, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL press_key0: got v=%0b i=%0d hp=%0d, want v=1 i=0 hp=28408",
                  note_valid, note_idx, half_period);
      end
      idle_cycles(10);
      tests++;
      if (chg_total - base !== 1) begin
         fails++;
         $display("FAIL press_key0_pulses: got %0d, want 1", chg_total - base);
      end
   endtask

   task automatic test_glitch;
      int base;
      base = chg_total;
      keys[4] = 1'b1;
      idle_cycles(6);
      keys[4] = 1'b0;
      idle_cycles(30);
      tests++;
      if (note_valid !== 1'b1 || note_idx !== 4'd0 || half_period !== 16'd28408) begin
         fails++;
         $display("FAIL glitch_outputs: got v=%0b i=%0d hp=%0d, want v=1 i=0 hp=28408",
                  note_valid, note_idx, half_period);
      end
      tests++;
      if (chg_total - base !== 0) begin
         fails++;
         $display("FAIL glitch_pulses: got %0d, want 0", chg_total - base);
      end
   endtask

   task automatic test_priority;
      bit ok;
      keys[7] = 1'b1;
      wait_out(1'b1, 4'd7, 16'd18959, 30, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL press_key7: got i=%0d hp=%0d, want i=7 hp=18959", note_idx, half_period);
      end
      keys[7] = 1'b0;
      wait_out(1'b1, 4'd0, 16'd28408, 30, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL release_key7: got i=%0d hp=%0d, want i=0 hp=28408", note_idx, half_period);
      end
      keys[0] = 1'b0;
      wait_out(1'b0, 4'd0, 16'd0, 30, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL release_key0: got v=%0b hp=%0d, want v=0 hp=0", note_valid, half_period);
      end
   endtask

   task automatic test_same_tick;
      int base;
      bit ok;
      keys[3] = 1'b1;
      keys[5] = 1'b1;
      wait_out(1'b1, 4'd3, 16'd23888, 30, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL press_3_5: got i=%0d hp=%0d, want i=3 hp=23888", note_idx, half_period);
      end
      idle_cycles(5);
      base = chg_total;
      keys[5] = 1'b0;
      idle_cycles(30);
      tests++;
      if (note_valid !== 1'b1 || note_idx !== 4'd3 || chg_total - base !== 0) begin
         fails++;
         $display("FAIL release_key5: got v=%0b i=%0d pulses=%0d, want v=1 i=3 pulses=0",
                  note_valid, note_idx, chg_total - base);
      end
      keys[3] = 1'b0;
      wait_out(1'b0, 4'd0, 16'd0, 30, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL release_key3: got v=%0b i=%0d, want idle", note_valid, note_idx);
      end
   endtask

   task automatic test_back_to_back;
      int base;
      bit ok;
      keys[0] = 1'b1;
      wait_out(1'b1, 4'd0, 16'd28408, 30, ok);
      idle_cycles(5);
      base = chg_total;
      keys[0] = 1'b0;
      keys[2] = 1'b1;
      wait_out(1'b1, 4'd2, 16'd25308, 30, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL swap_0_to_2: got v=%0b i=%0d hp=%0d, want v=1 i=2 hp=25308",
                  note_valid, note_idx, half_period);
      end
      idle_cycles(10);
      tests++;
      if (chg_total - base !== 1) begin
         fails++;
         $display("FAIL swap_pulses: got %0d, want 1", chg_total - base);
      end
      keys[2] = 1'b0;
      wait_out(1'b0, 4'd0, 16'd0, 30, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL release_key2: got v=%0b i=%0d, want idle", note_valid, note_idx);
      end
   endtask

   task automatic test_async_reset;
      int base;
      bit ok;
      keys[11] = 1'b1;
      wait_out(1'b1, 4'd11, 16'd15048, 30, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL press_key11: got i=%0d hp=%0d, want i=11 hp=15048", note_idx, half_period);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({note_valid, note_idx, half_period, note_changed} !== 22'd0) begin
         fails++;
         $display("FAIL async_reset: got v=%0b i=%0d hp=%0d, want all 0",
                  note_valid, note_idx, half_period);
      end
      idle_cycles(3);
      base = chg_total;
      rst_n = 1'b1;
      wait_out(1'b1, 4'd11, 16'd15048, 30, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL redetect_key11: got v=%0b i=%0d hp=%0d, want v=1 i=11 hp=15048",
                  note_valid, note_idx, half_period);
      end
      idle_cycles(10);
      tests++;
      if (chg_total - base !== 1) begin
         fails++;
         $display("FAIL redetect_pulses: got %0d, want 1", chg_total - base);
      end
   endtask

   initial begin
      test_reset;
      test_single_press;
      test_glitch;
      test_priority;
      test_same_tick;
      test_back_to_back;
      test_async_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
